// File: rtl/sw_pkg.sv
// Shared types and scoring constants for the Smith-Waterman systolic array.
// Scores are 12-bit; NINF marks an unreachable gap state at the boundary.
package sw_pkg;
   localparam int SYM_W = 2;
   localparam int SCORE_W = 12;
   localparam logic [SCORE_W-1:0] NINF = 12'hE00;
   localparam int MATCH_SCORE = 8;
   // penalty magnitude, subtracted by the PE on a symbol mismatch
   localparam int MISMATCH_SCORE = 5;
   localparam int OPEN_SCORE = -7;
   localparam int EXTENSION_SCORE = -3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;
endpackage

// File: rtl/sw_tbuf.sv
// Target symbol buffer: simple dual-port RAM with a registered read port.
// A same-cycle write to the read address is forwarded to the output.
module sw_tbuf
   import sw_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [SYM_W-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [SYM_W-1:0] o_rdata
);
   logic [SYM_W-1:0] r_mem [DEPTH];
   logic [SYM_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/sw_array_ctrl.sv
// Job sequencer for a linear Smith-Waterman PE chain: buffers the target,
// streams it bubble-free into PE0 and returns the final local score.
module sw_array_ctrl
   import sw_pkg::*;
#(
   parameter int NUM_PE = 16,
   parameter int MAX_T  = 256,
   parameter int TLEN_W = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2*NUM_PE-1:0]   q_in,
   output logic                  busy,
   input  logic                  t_valid,
   output logic                  t_ready,
   input  logic [SYM_W-1:0]      t_data,
   input  logic                  t_last,
   output logic [2*NUM_PE-1:0]   arr_s,
   output logic                  arr_valid,
   output logic [SYM_W-1:0]      arr_t,
   output logic [SCORE_W-1:0]    arr_v,
   output logic [SCORE_W-1:0]    arr_f,
   output logic [SCORE_W-1:0]    arr_max,
   input  logic                  arr_valid_out,
   input  logic [SCORE_W-1:0]    arr_max_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [SCORE_W-1:0]    res_score,
   output logic [TLEN_W-1:0]     res_len,
   output logic                  res_trunc
);
   localparam int AW = $clog2(MAX_T);
   localparam logic [TLEN_W-1:0] LP_MAX_T = TLEN_W'(MAX_T);

   state_e              r_state;
   state_e              w_next;
   logic [TLEN_W-1:0]   r_wptr;
   logic [TLEN_W-1:0]   r_rptr;
   logic [TLEN_W-1:0]   r_tlen;
   logic [SCORE_W-1:0]  r_score;
   logic                r_trunc;
   logic                r_seen;
   logic [2*NUM_PE-1:0] r_arr_s;
   logic                w_beat;
   logic                w_room;
   logic                w_we;
   logic [AW-1:0]       w_raddr;

   assign w_beat = (r_state == ST_LOAD) && t_valid;
   assign w_room = (r_wptr < LP_MAX_T);
   assign w_we   = w_beat && w_room;
   // address 0 outside RUN prefetches the first symbol for RUN cycle 0
   assign w_raddr = (r_state == ST_RUN) ? AW'(r_rptr + 1'b1) : '0;

   sw_tbuf #(.DEPTH(MAX_T), .AW(AW)) u_tbuf (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (r_wptr[AW-1:0]),
      .i_wdata (t_data),
      .i_raddr (w_raddr),
      .o_rdata (arr_t)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b1;
      t_ready   = 1'b0;
      arr_valid = 1'b0;
      res_valid = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            t_ready = 1'b1;
            if (w_beat && t_last) w_next = ST_RUN;
         end
         ST_RUN: begin
            arr_valid = 1'b1;
            if (r_rptr == r_tlen - 1'b1) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!arr_valid_out && r_seen) w_next = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_tlen  <= '0;
         r_score <= '0;
         r_trunc <= 1'b0;
         r_seen  <= 1'b0;
         r_arr_s <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_arr_s <= q_in;
                  r_wptr  <= '0;
                  r_rptr  <= '0;
                  r_tlen  <= '0;
                  r_score <= '0;
                  r_trunc <= 1'b0;
                  r_seen  <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_beat) begin
                  if (w_room) r_wptr <= r_wptr + 1'b1;
                  else        r_trunc <= 1'b1;
                  if (t_last) r_tlen <= w_room ? r_wptr + 1'b1 : r_wptr;
               end
            end
            ST_RUN: r_rptr <= r_rptr + 1'b1;
            ST_DRAIN: begin
               if (arr_valid_out) begin
                  r_score <= arr_max_out;
                  r_seen  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign arr_s     = r_arr_s;
   assign arr_v     = '0;
   assign arr_f     = NINF;
   assign arr_max   = '0;
   assign res_score = r_score;
   assign res_len   = r_tlen;
   assign res_trunc = r_trunc;
endmodule

// File: tb/tb_sw_array_ctrl.sv
// Bench for sw_array_ctrl with a behavioural PE-chain model and a
// Gotoh affine-gap reference for the expected local alignment score.
module tb_sw_array_ctrl;
   localparam int NP = 4;
   localparam int MT = 8;
   localparam int TW = 4;
   localparam int NEG = -10000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [2*NP-1:0] q_in = '0;
   logic            busy;
   logic            t_valid = 1'b0;
   logic            t_ready;
   logic [1:0]      t_data = '0;
   logic            t_last = 1'b0;
   logic [2*NP-1:0] arr_s;
   logic            arr_valid;
   logic [1:0]      arr_t;
   logic [11:0]     arr_v;
   logic [11:0]     arr_f;
   logic [11:0]     arr_max;
   logic            arr_valid_out;
   logic [11:0]     arr_max_out;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [11:0]     res_score;
   logic [TW-1:0]   res_len;
   logic            res_trunc;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sw_array_ctrl #(.NUM_PE(NP), .MAX_T(MT), .TLEN_W(TW)) dut (
      .clk(clk), .rst(rst), .start(start), .q_in(q_in), .busy(busy),
      .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data),
      .t_last(t_last), .arr_s(arr_s), .arr_valid(arr_valid),
      .arr_t(arr_t), .arr_v(arr_v), .arr_f(arr_f), .arr_max(arr_max),
      .arr_valid_out(arr_valid_out), .arr_max_out(arr_max_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_score(res_score), .res_len(res_len), .res_trunc(res_trunc)
   );

   function automatic int mx(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // best local score of query q against target t (Gotoh recurrence)
   function automatic int sw_ref(input logic [2*NP-1:0] q, input int t[$]);
      int hp[NP+1];
      int ep[NP+1];
      int hc[NP+1];
      int ec[NP+1];
      int f;
      int s;
      int best;
      best = 0;
      for (int i = 0; i <= NP; i++) begin
         hp[i] = 0;
         ep[i] = NEG;
      end
      for (int j = 0; j < t.size(); j++) begin
         hc[0] = 0;
         ec[0] = NEG;
         f = NEG;
         for (int i = 1; i <= NP; i++) begin
            s = (int'(q[2*(i-1) +: 2]) == t[j]) ? 8 : -5;
            ec[i] = mx(hp[i] - 7, ep[i] - 3);
            f = mx(hc[i-1] - 7, f - 3);
            hc[i] = mx(mx(0, hp[i-1] + s), mx(ec[i], f));
            best = mx(best, hc[i]);
         end
         for (int i = 0; i <= NP; i++) begin
            hp[i] = hc[i];
            ep[i] = ec[i];
         end
      end
      return best;
   endfunction

   // PE chain model: NP cycles of latency, running best score per column
   logic [NP-1:0]   vpipe;
   logic [11:0]     mpipe [NP];
   logic [2*NP-1:0] mq;
   int              mcol[$];

   assign arr_valid_out = vpipe[NP-1];
   assign arr_max_out   = mpipe[NP-1];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe <= '0;
         for (int k = 0; k < NP; k++) mpipe[k] <= '0;
         mcol.delete();
      end else begin
         vpipe <= {vpipe[NP-2:0], arr_valid};
         for (int k = 1; k < NP; k++) mpipe[k] <= mpipe[k-1];
         if (arr_valid) begin
            if (mcol.size() == 0) mq = arr_s;
            mcol.push_back(int'(arr_t));
            mpipe[0] <= 12'(sw_ref(mq, mcol));
         end else begin
            mcol.delete();
            mpipe[0] <= '0;
         end
      end
   end

   int run_start;
   int vcnt;
   int vo_first;
   int vo_last;
   bit vo_seen;

   always @(negedge clk) begin
      if (!busy) begin
         vcnt = 0;
         vo_seen = 0;
         run_start = -1;
         vo_first = -1;
         vo_last = -1;
      end else begin
         if (arr_valid) begin
            if (vcnt == 0) run_start = cyc;
            vcnt++;
         end
         if (arr_valid_out) begin
            if (!vo_seen) vo_first = cyc;
            vo_seen = 1;
            vo_last = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [2*NP-1:0] jq;
   int tq[$];

   task automatic start_job();
      chk("idle_arr_valid", 32'(arr_valid), 0);
      chk("idle_busy", 32'(busy), 0);
      start = 1'b1;
      q_in = jq;
      @(negedge clk);
      start = 1'b0;
      q_in = ~jq;
      chk("busy_after_start", 32'(busy), 1);
      chk("arr_s_latched", 32'(arr_s), 32'(jq));
   endtask

   task automatic feed();
      for (int i = 0; i < tq.size(); i++) begin
         if ($urandom_range(0, 3) == 0) begin
            t_valid = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         t_valid = 1'b1;
         t_data = 2'(tq[i]);
         t_last = (i == tq.size() - 1);
         chk("t_ready_beat", 32'(t_ready), 1);
         @(negedge clk);
      end
      t_valid = 1'b0;
      t_last = 1'b0;
   endtask

   task automatic finish_job(input int hold, input bit poke, input int want);
      int n;
      int kept;
      int exp_score;
      int kq[$];
      n = 0;
      while (!res_valid && n < 300) begin
         t_valid = 1'b1;
         t_data = 2'($urandom);
         @(negedge clk);
         n++;
      end
      t_valid = 1'b0;
      chk("res_valid_timeout", 32'(res_valid), 1);
      if (!res_valid) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      kept = (tq.size() > MT) ? MT : tq.size();
      for (int i = 0; i < kept; i++) kq.push_back(tq[i]);
      exp_score = sw_ref(jq, kq);
      chk("res_score", 32'(res_score), 32'(exp_score));
      if (want >= 0) chk("res_score_plan", 32'(res_score), 32'(want));
      chk("res_len", 32'(res_len), 32'(kept));
      chk("res_trunc", 32'(res_trunc), 32'(tq.size() > MT));
      chk("arr_valid_cycles", 32'(vcnt), 32'(kept));
      chk("vout_first", 32'(vo_first), 32'(run_start + NP));
      chk("vout_last", 32'(vo_last), 32'(run_start + NP + kept - 1));
      chk("arr_s_held", 32'(arr_s), 32'(jq));
      for (int h = 0; h < hold; h++) begin
         if (poke && h == 2) begin
            start = 1'b1;
            q_in = ~jq;
         end
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid", 32'(res_valid), 1);
         chk("hold_score", 32'(res_score), 32'(exp_score));
         chk("hold_len", 32'(res_len), 32'(kept));
         chk("hold_arr_s", 32'(arr_s), 32'(jq));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("idle_after_ready", 32'(busy), 0);
      chk("res_valid_dropped", 32'(res_valid), 0);
   endtask

   task automatic run_job(input int hold, input bit poke, input int want);
      start_job();
      feed();
      finish_job(hold, poke, want);
   endtask

   initial begin
      int n;
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_t_ready", 32'(t_ready), 0);
      chk("rst_arr_valid", 32'(arr_valid), 0);
      chk("rst_arr_t", 32'(arr_t), 0);
      chk("rst_arr_s", 32'(arr_s), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_score", 32'(res_score), 0);
      chk("rst_res_len", 32'(res_len), 0);
      chk("rst_res_trunc", 32'(res_trunc), 0);
      chk("arr_f_ninf", 32'(arr_f), 32'h0E00);
      chk("arr_v_zero", 32'(arr_v), 0);
      chk("arr_max_zero", 32'(arr_max), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      jq = {2'd3, 2'd2, 2'd1, 2'd0};
      tq = '{0, 1, 2, 3};
      run_job(0, 0, 32);

      jq = '0;
      tq = '{0};
      run_job(1, 0, 8);

      tq = '{1, 1, 1, 1};
      run_job(0, 0, 0);

      jq = {2'd3, 2'd2, 2'd1, 2'd0};
      tq.delete();
      for (int i = 0; i < 10; i++) tq.push_back(int'($urandom_range(0, 3)));
      run_job(20, 1, -1);

      tq = '{2, 3};
      run_job(0, 0, 16);

      jq = 8'($urandom);
      tq = '{0, 1, 2, 3, 0, 1};
      start_job();
      feed();
      n = 0;
      while (!arr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("run_reached", 32'(arr_valid), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrun_rst_valid", 32'(arr_valid), 0);
      chk("midrun_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      jq = {2'd3, 2'd2, 2'd1, 2'd0};
      tq = '{0, 1, 2, 3};
      run_job(0, 0, 32);

      for (int j = 0; j < 12; j++) begin
         jq = 8'($urandom);
         tq.delete();
         n = $urandom_range(1, 11);
         for (int i = 0; i < n; i++) tq.push_back(int'($urandom_range(0, 3)));
         run_job($urandom_range(0, 3), 1'($urandom), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
Sequencer for a linear systolic array of NUM_PE Smith-Waterman affine-gap PEs (one query symbol per PE). It captures a job's query, buffers a whole target sequence so the array sees a bubble-free stream, drives the array's PE0 boundary inputs and collects the final local-alignment score from the last PE. It returns one result per job through a valid/ready handshake. It sits between the host/DMA interface and the PE chain.

Parameters:
NUM_PE, 16, PEs in the array; query length is fixed at NUM_PE
MAX_T, 256, target buffer depth in symbols
TLEN_W, 9, target-length counter width; must satisfy 2^TLEN_W > MAX_T

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  job start pulse; honoured only in IDLE
q_in  in  2*NUM_PE  query symbols, PE k at bits [2k+1:2k]; sampled on accepted start
busy  out  1  high in every state except IDLE
t_valid  in  1  target symbol valid
t_ready  out  1  high in LOAD only
t_data  in  2  target symbol
t_last  in  1  last target symbol of the job
arr_s  out  2*NUM_PE  registered query to the PE s_in ports; stable from accepted start until IDLE
arr_valid  out  1  PE0 valid_in
arr_t  out  2  PE0 t_in
arr_v  out  12  PE0 v_in boundary, constant 0
arr_f  out  12  PE0 f_in boundary, constant NINF (12'hE00)
arr_max  out  12  PE0 max_in boundary, constant 0
arr_valid_out  in  1  last PE valid_out
arr_max_out  in  12  last PE max_out
res_valid  out  1  result available
res_ready  in  1  result consumed
res_score  out  12  best local score, unsigned
res_len  out  TLEN_W  target symbols processed
res_trunc  out  1  target exceeded MAX_T and was truncated

Behaviour:
- Reset is asynchronous and active-high. Reset values: state IDLE, busy 0, t_ready 0, arr_valid 0, arr_t 0, arr_s 0, res_valid 0, res_score 0, res_len 0, res_trunc 0, write pointer 0, read pointer 0. Reset mid-job abandons the job; arr_valid goes low immediately.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: on start, latch q_in into arr_s, clear counters, clear trunc and score, go to LOAD.
- LOAD: t_ready=1. Each t_valid beat is written at wptr while wptr<MAX_T. Beats arriving when wptr==MAX_T are dropped and set trunc. A t_last beat (kept or dropped) ends LOAD and moves to RUN next cycle with tlen=wptr.
- RUN: arr_valid=1 for exactly tlen consecutive cycles. arr_t = buf[rptr]; the buffer read is registered so the first symbol is valid in the first RUN cycle (prefetch during the final LOAD cycle). After tlen cycles, arr_valid=0 and the block goes to DRAIN.
- PE k latches its query symbol on its first valid cycle. arr_s is therefore held constant through DRAIN.
- DRAIN: on every cycle with arr_valid_out=1, register arr_max_out into score. The first cycle with arr_valid_out=0, after at least one high cycle, moves to DONE.
- Required latency: arr_valid_out is high for cycles RUN_start+NUM_PE through RUN_start+NUM_PE+tlen-1.
- DONE: res_valid=1, with res_score, res_len=tlen and res_trunc held stable until res_ready; then IDLE. A start pulse during DONE is ignored.
- Inter-job gap: arr_valid is low throughout DONE, IDLE and LOAD, so every PE sees at least one invalid cycle and returns to idle before the next job.
- Widths: scores are 12-bit unsigned and pass through unmodified. There is no saturation in this block.
- start while busy: ignored, no side effects. t_valid outside LOAD: ignored (t_ready=0).

Decomposition:
- Package sw_pkg holds: SYM_W=2, SCORE_W=12, NINF=12'hE00, MATCH_SCORE=8, MISMATCH_SCORE=5, OPEN_SCORE=-7, EXTENSION_SCORE=-3, and the state encoding.
- One sub-module, sw_tbuf: a MAX_T x 2 simple dual-port buffer with a registered read port.
- Counters and the state machine stay in sw_array_ctrl.

Test Plan:
- NUM_PE=4, query ACGT (0,1,2,3), target ACGT with t_last on beat 4, array of real PEs -> res_score=32, res_len=4, res_trunc=0; arr_valid high exactly 4 cycles; arr_valid_out high at cycles RUN_start+4 through RUN_start+7.
- Query AAAA, single-beat target A with t_last -> res_score=8, res_len=1.
- Query AAAA, target CCCC -> res_score=0.
- MAX_T=8, send 10 beats with t_last on beat 10 -> res_len=8, res_trunc=1; t_ready stays high for all 10 beats; arr_valid high exactly 8 cycles.
- Hold res_ready=0 for 20 cycles, and pulse start during DONE -> outputs stable, start ignored. Then res_ready=1 -> IDLE; a second job (query ACGT, target GT) gives res_score=16, with arr_valid low for at least 1 cycle between jobs.
- Assert rst for 1 cycle in the middle of RUN -> arr_valid=0 and busy=0 immediately; the next job completes with the correct score.
